xmem_arbiter: RTL and testbench
===============================

Name: xmem_arbiter

Overview:
- Sequencer and two-port arbiter for the 8-bit multiplexed external SRAM bus (address latches '373 low/high, byte-wide SRAM, A0 = byte select).
- Shares the bus between port 0 (CPU) and port 1 (DMA requester, e.g. UART block transfer) with round-robin arbitration.
- Converts each 16-bit word request into an address-low / address-high / byte-low / byte-high pin sequence and returns the read word through a req/ack handshake.

Parameters:
- WAITS, 0, extra wait cycles added to each byte phase (B0, B1); honoured only with XMEM_WAIT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 request; held with addr0/we0/wd0 stable until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  16  port 0 word address
- wd0  in  16  port 0 write data
- ack0  out  1  port 0 one-cycle completion pulse
- rd0  out  16  port 0 read data; valid from ack0, held until the next port 0 read ack
- req1, we1, addr1, wd1, ack1, rd1: same as port 0, for port 1
- xd_out  out  8  external bus drive data
- xd_oe  out  1  external bus output enable (1 = drive)
- xd_in  in  8  external bus input data
- xlal  out  1  latch address low strobe
- xlah  out  1  latch address high strobe
- xbh  out  1  SRAM A0 (1 = high byte)
- xoeb  out  1  SRAM /OE
- xweb  out  1  SRAM /WE

Behaviour:
- All outputs are registered from the state machine; no combinational path from req to pins.
- States: IDLE, AL, AH, B0, B1, ACK.
- IDLE:
  - If only one req is high, grant that port.
  - If both are high, grant the port not served last. The last-served flag resets to 1, so port 0 wins the first tie.
  - On a grant, latch port index, we, addr and wdata into internal registers, then go to AL.
- AL (1 cycle): xd_out=addr[7:0], xd_oe=1, xlal=1.
- AH (1 cycle): xd_out=addr[15:8], xd_oe=1, xlah=1.
- B0 (1+W cycles), xbh=0:
  - Write: xd_out=wdata[7:0], xd_oe=1, xweb=0.
  - Read: xd_oe=0, xoeb=0; capture xd_in into the low byte at the last B0 cycle.
- B1 (1+W cycles), xbh=1:
  - Write: xd_out=wdata[15:8], xd_oe=1, xweb=0.
  - Read: xoeb=0; capture xd_in into the high byte at the last B1 cycle.
- ACK (1 cycle):
  - Pulse ackN for the granted port.
  - On a read, load rdN with the captured word. rdN is unchanged on writes, and the other port's rd is untouched.
  - Update the last-served flag, then go to IDLE.
- Requester must drop req on the edge after ack, or keep it high to request a new access; that access is sampled in IDLE.
- Latency with W=0: req high in IDLE cycle N gives AL at N+1 and ack at N+5. Throughput is one word per 6 cycles; under contention the ports alternate.
- Idle pin values: xd_oe=0, xd_out=0, xlal=xlah=xbh=0, xoeb=xweb=1.
- Only one of xoeb/xweb is ever low, and never while xlal or xlah is high.
- req changing between grant and ack is ignored, because the request was latched at grant.
- Reset, including mid-access:
  - All pins go to idle values asynchronously.
  - ack0=ack1=0, rd0=rd1=0, state=IDLE, last-served=1.
  - An aborted access is never acknowledged.

Optional Feature:
- XMEM_WAIT_EN defined: a wait counter stretches B0 and B1 to 1+WAITS cycles each. Pin values are held through the whole phase, and read data is captured on the final cycle.
- XMEM_WAIT_EN undefined: WAITS is ignored, B0 and B1 last exactly 1 cycle, and no counter is synthesised.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=0, AL=1, AH=2, B0=3, B1=4, ACK=5;
  - port index constants: PORT_CPU=0, PORT_DMA=1.
- One natural sub-module, xmem_rr2: a 2-input round-robin picker (req0, req1, last → grant, valid). The FSM and pin drivers stay in xmem_arbiter.

Test Plan:
- Port 0 write addr=0x1234, wd=0xBEEF, W=0:
  - AL xd_out=0x34 with xlal; AH 0x12 with xlah; B0 0xEF with xweb=0, xbh=0; B1 0xBE with xweb=0, xbh=1.
  - ack0 at N+5.
- Port 1 read addr=0x0040, SRAM model returns 0x5A (low) and 0xC3 (high):
  - xoeb=0 in B0/B1, xd_oe=0.
  - rd1=0xC35A with ack1; rd0 unchanged.
- req0 and req1 both high and held continuously:
  - Grants go 0,1,0,1; each ack 6 cycles apart; no port served twice while the other waits.
- rst_n low during B0 of a write:
  - xweb=1, xd_oe=0 immediately.
  - No ack; after release the first tie goes to port 0.
- XMEM_WAIT_EN with WAITS=2, read:
  - B0 and B1 each 3 cycles; ack at N+9.
  - Data changed on xd_in before the final B-cycle is not captured.
- Back-to-back on port 0 (req held through ack):
  - Second access starts AL 2 cycles after the first ack.
  - Pin checker confirms xoeb and xweb are never both low and never low together with xlal or xlah.

Source files
------------

// File: rtl/xmem_arbiter_pkg.sv
// rtl/xmem_arbiter_pkg.sv - shared state/port encodings and pin-pattern helper for the external SRAM sequencer
package xmem_arbiter_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AL   = 3'd1;
    localparam logic [2:0] AH   = 3'd2;
    localparam logic [2:0] B0   = 3'd3;
    localparam logic [2:0] B1   = 3'd4;
    localparam logic [2:0] ACK  = 3'd5;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef struct packed {
        logic [7:0] xd;
        logic       oe;
        logic       lal;
        logic       lah;
        logic       bh;
        logic       oeb;
        logic       web;
    } pins_t;

    localparam pins_t PINS_IDLE = '{xd: 8'h00, oe: 1'b0, lal: 1'b0, lah: 1'b0,
                                    bh: 1'b0, oeb: 1'b1, web: 1'b1};

    // Pin pattern held for the whole duration of a state.
    function automatic pins_t pins_for(input logic [2:0]  st,
                                       input logic        we,
                                       input logic [15:0] addr,
                                       input logic [15:0] wd);
        pins_t p;
        p = PINS_IDLE;
        case (st)
            AL: begin
                p.xd  = addr[7:0];
                p.oe  = 1'b1;
                p.lal = 1'b1;
            end
            AH: begin
                p.xd  = addr[15:8];
                p.oe  = 1'b1;
                p.lah = 1'b1;
            end
            B0: begin
                if (we) begin
                    p.xd  = wd[7:0];
                    p.oe  = 1'b1;
                    p.web = 1'b0;
                end else begin
                    p.oeb = 1'b0;
                end
            end
            B1: begin
                p.bh = 1'b1;
                if (we) begin
                    p.xd  = wd[15:8];
                    p.oe  = 1'b1;
                    p.web = 1'b0;
                end else begin
                    p.oeb = 1'b0;
                end
            end
            default: p = PINS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/xmem_rr2.sv
// rtl/xmem_rr2.sv - two-input round-robin picker; a tie goes to the port not served last
module xmem_rr2
    import xmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant,
    output logic valid
);

    assign valid = req0 | req1;
    assign grant = (req0 & req1) ? ~last : (req1 ? PORT_DMA : PORT_CPU);

endmodule

// File: rtl/xmem_arbiter.sv
// rtl/xmem_arbiter.sv - two-port round-robin sequencer for the multiplexed 8-bit external SRAM bus
// XMEM_WAIT_EN: stretch each byte phase by WAITS cycles
module xmem_arbiter
    import xmem_arbiter_pkg::*;
#(
    parameter int unsigned WAITS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wd0,
    output logic        ack0,
    output logic [15:0] rd0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wd1,
    output logic        ack1,
    output logic [15:0] rd1,
    output logic [7:0]  xd_out,
    output logic        xd_oe,
    input  logic [7:0]  xd_in,
    output logic        xlal,
    output logic        xlah,
    output logic        xbh,
    output logic        xoeb,
    output logic        xweb
);

    logic [2:0]  state, state_n;
    logic        port_q, port_n;
    logic        we_q, we_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] wd_q, wd_n;
    logic        last_q;
    logic [7:0]  lo_q;
    logic        gnt, gvalid;
    logic        b_last;
    pins_t       pins_q;

    xmem_rr2 u_rr2 (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .grant (gnt),
        .valid (gvalid)
    );

`ifdef XMEM_WAIT_EN
    localparam int unsigned WCW = (WAITS < 1) ? 1 : $clog2(WAITS + 1);
    logic [WCW-1:0] wcnt;

    assign b_last = (wcnt == WCW'(WAITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (((state == B0) || (state == B1)) && !b_last) begin
            wcnt <= wcnt + 1'b1;
        end else begin
            wcnt <= '0;
        end
    end
`else
    assign b_last = 1'b1;
`endif

    always_comb begin
        state_n = state;
        port_n  = port_q;
        we_n    = we_q;
        addr_n  = addr_q;
        wd_n    = wd_q;
        case (state)
            IDLE: begin
                if (gvalid) begin
                    state_n = AL;
                    port_n  = gnt;
                    if (gnt == PORT_DMA) begin
                        we_n   = we1;
                        addr_n = addr1;
                        wd_n   = wd1;
                    end else begin
                        we_n   = we0;
                        addr_n = addr0;
                        wd_n   = wd0;
                    end
                end
            end
            AL:      state_n = AH;
            AH:      state_n = B0;
            B0:      state_n = b_last ? B1 : B0;
            B1:      state_n = b_last ? ACK : B1;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pins and acks are computed from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            port_q <= PORT_CPU;
            we_q   <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
            last_q <= PORT_DMA;
            lo_q   <= '0;
            pins_q <= PINS_IDLE;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rd0    <= '0;
            rd1    <= '0;
        end else begin
            state  <= state_n;
            port_q <= port_n;
            we_q   <= we_n;
            addr_q <= addr_n;
            wd_q   <= wd_n;
            pins_q <= pins_for(state_n, we_n, addr_n, wd_n);
            ack0   <= (state_n == ACK) && (port_n == PORT_CPU);
            ack1   <= (state_n == ACK) && (port_n == PORT_DMA);
            if ((state == B0) && b_last && !we_q) begin
                lo_q <= xd_in;
            end
            if ((state == B1) && b_last && !we_q) begin
                if (port_q == PORT_DMA) begin
                    rd1 <= {xd_in, lo_q};
                end else begin
                    rd0 <= {xd_in, lo_q};
                end
            end
            if (state == ACK) begin
                last_q <= port_q;
            end
        end
    end

    assign xd_out = pins_q.xd;
    assign xd_oe  = pins_q.oe;
    assign xlal   = pins_q.lal;
    assign xlah   = pins_q.lah;
    assign xbh    = pins_q.bh;
    assign xoeb   = pins_q.oeb;
    assign xweb   = pins_q.web;

endmodule

// File: tb/tb_xmem_arbiter.sv
// tb/tb_xmem_arbiter.sv - randomized bench for xmem_arbiter against a word-level timeline model and byte SRAM
module tb_xmem_arbiter;

`ifdef XMEM_WAIT_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam int ACK_OFF = 5 + 2 * W;
    localparam logic [13:0] IDLE_V = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
    } txn_t;

    logic        clk, rst_n;
    logic        req0, we0, ack0, req1, we1, ack1;
    logic [15:0] addr0, wd0, rd0, addr1, wd1, rd1;
    logic [7:0]  xd_out, xd_in;
    logic        xd_oe, xlal, xlah, xbh, xoeb, xweb;

    xmem_arbiter #(.WAITS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wd0(wd0), .ack0(ack0), .rd0(rd0),
        .req1(req1), .we1(we1), .addr1(addr1), .wd1(wd1), .ack1(ack1), .rd1(rd1),
        .xd_out(xd_out), .xd_oe(xd_oe), .xd_in(xd_in),
        .xlal(xlal), .xlah(xlah), .xbh(xbh), .xoeb(xoeb), .xweb(xweb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // External SRAM: address latches plus byte array with address-derived default contents
    logic [7:0]  lat_lo, lat_hi;
    logic [7:0]  sram [int];
    logic [15:0] ref_mem [int];

    function automatic logic [7:0] init_byte(input logic [16:0] a);
        return a[8:1] ^ a[16:9] ^ {a[0], 7'h2B};
    endfunction

    function automatic logic [7:0] sram_rd(input logic [16:0] a);
        if (sram.exists(int'(a))) return sram[int'(a)];
        return init_byte(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return {init_byte({a, 1'b1}), init_byte({a, 1'b0})};
    endfunction

    task automatic sram_cycle();
        if (xlal) lat_lo = xd_out;
        if (xlah) lat_hi = xd_out;
        if (!xweb) sram[int'({lat_hi, lat_lo, xbh})] = xd_out;
    endtask

    // Requester queues and reference model state
    txn_t q0[$], q1[$];
    int   cyc;
    bit   m_busy, m_port, m_last;
    txn_t m_t;
    int   m_gcyc, m_next_idle;
    logic [15:0] exp_rd0, exp_rd1;
    int   obs_port[$], obs_cyc[$];
    logic [15:0] pool [8] = '{16'h1234, 16'h0040, 16'hFFFF, 16'h0000,
                              16'hA5C3, 16'h8001, 16'h00FF, 16'h7F80};

    function automatic txn_t rand_txn();
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.addr = pool[$urandom_range(0, 7)];
        t.wd   = 16'($urandom);
        return t;
    endfunction

    function automatic logic [13:0] mk(input logic [7:0] d, input logic oe, input logic lal,
                                       input logic lah, input logic bh, input logic oeb,
                                       input logic web);
        return {d, oe, lal, lah, bh, oeb, web};
    endfunction

    // Expected pins from the position within an access: AL, AH, B0 x(1+W), B1 x(1+W), ACK
    function automatic logic [13:0] exp_pin(input int off, input txn_t t);
        if (off == 1) return mk(t.addr[7:0], 1, 1, 0, 0, 1, 1);
        if (off == 2) return mk(t.addr[15:8], 1, 0, 1, 0, 1, 1);
        if (off >= 3 && off <= 3 + W)
            return t.we ? mk(t.wd[7:0], 1, 0, 0, 0, 1, 0) : mk(8'h00, 0, 0, 0, 0, 0, 1);
        if (off >= 4 + W && off <= 4 + 2 * W)
            return t.we ? mk(t.wd[15:8], 1, 0, 0, 1, 1, 0) : mk(8'h00, 0, 0, 0, 1, 0, 1);
        return IDLE_V;
    endfunction

    task automatic drive();
        txn_t t;
        req0 = (q0.size() > 0);
        if (req0) begin t = q0[0]; we0 = t.we; addr0 = t.addr; wd0 = t.wd; end
        else begin we0 = 1'($urandom); addr0 = 16'($urandom); wd0 = 16'($urandom); end
        req1 = (q1.size() > 0);
        if (req1) begin t = q1[0]; we1 = t.we; addr1 = t.addr; wd1 = t.wd; end
        else begin we1 = 1'($urandom); addr1 = 16'($urandom); wd1 = 16'($urandom); end
    endtask

    task automatic arbitrate();
        if (!m_busy && cyc >= m_next_idle && (req0 || req1)) begin
            m_port = (req0 && req1) ? !m_last : req1;
            m_t    = m_port ? q1[0] : q0[0];
            m_busy = 1'b1;
            m_gcyc = cyc;
        end
    endtask

    task automatic step(input bit gen);
        int          off;
        bit          ack_now, ok;
        logic [13:0] ep, op;
        @(negedge clk);
        cyc++;
        off     = cyc - m_gcyc;
        ep      = m_busy ? exp_pin(off, m_t) : IDLE_V;
        ack_now = m_busy && (off == ACK_OFF);
        sram_cycle();
        // Only the final cycle of each read byte phase presents real data
        if (m_busy && !m_t.we && (off == 3 + W || off == 4 + 2 * W))
            xd_in = sram_rd({lat_hi, lat_lo, xbh});
        else
            xd_in = 8'($urandom);
        if (ack_now) begin
            if (m_t.we) ref_mem[int'(m_t.addr)] = m_t.wd;
            else if (m_port) exp_rd1 = ref_rd(m_t.addr);
            else exp_rd0 = ref_rd(m_t.addr);
            if (m_port) void'(q1.pop_front());
            else void'(q0.pop_front());
            m_last      = m_port;
            m_busy      = 1'b0;
            m_next_idle = cyc + 1;
        end
        if (ack0 || ack1) begin
            obs_port.push_back(int'(ack1));
            obs_cyc.push_back(cyc);
        end
        chk("ack0", 32'(ack0), 32'(ack_now && !m_port));
        chk("ack1", 32'(ack1), 32'(ack_now && m_port));
        chk("rd0", 32'(rd0), 32'(exp_rd0));
        chk("rd1", 32'(rd1), 32'(exp_rd1));
        op = {xd_out, xd_oe, xlal, xlah, xbh, xoeb, xweb};
        if (!ep[5]) op[13:6] = 8'h00;
        chk("pins", 32'(op), 32'(ep));
        ok = !(!xoeb && !xweb) && !((!xoeb || !xweb) && (xlal || xlah));
        chk("pin_excl", 32'(ok), 32'd1);
        if (gen) begin
            if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_txn());
            if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
        end
        drive();
        arbitrate();
    endtask

    task automatic run_until_idle(input int max, input string tag);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < max) begin
            step(1'b0);
            n++;
        end
        chk(tag, 32'(n < max), 32'd1);
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < obs_cyc.size(); i++)
            chk(tag, 32'(obs_cyc[i] - obs_cyc[i-1]), 32'(ACK_OFF + 1));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pins", 32'({xd_out, xd_oe, xlal, xlah, xbh, xoeb, xweb}), 32'(IDLE_V));
        chk("rst_ack", 32'({ack0, ack1}), 32'd0);
        chk("rst_rd", 32'({rd0, rd1}), 32'd0);
        m_busy  = 1'b0;
        m_last  = 1'b1;
        exp_rd0 = '0;
        exp_rd1 = '0;
        repeat (2) begin
            @(negedge clk);
            cyc++;
            chk("rst_hold_ack", 32'({ack0, ack1}), 32'd0);
            chk("rst_hold_pins", 32'({xd_out, xd_oe, xlal, xlah, xbh, xoeb, xweb}), 32'(IDLE_V));
        end
        obs_port.delete();
        obs_cyc.delete();
        q1.push_back(rand_txn());
        drive();
        rst_n       = 1'b1;
        m_next_idle = cyc;
        arbitrate();
    endtask

    initial begin
        txn_t t;
        int   n;
        rst_n = 1'b0;
        xd_in = 8'h00;
        lat_lo = 8'h00;
        lat_hi = 8'h00;
        cyc = 0;
        m_busy = 1'b0;
        m_last = 1'b1;
        m_gcyc = 0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        drive();
        repeat (3) @(negedge clk);
        chk("reset_pins", 32'({xd_out, xd_oe, xlal, xlah, xbh, xoeb, xweb}), 32'(IDLE_V));
        chk("reset_ack", 32'({ack0, ack1}), 32'd0);
        chk("reset_rd", 32'({rd0, rd1}), 32'd0);
        rst_n = 1'b1;
        m_next_idle = cyc;
        arbitrate();

        // Port 0 write, then port 1 read of a preloaded word
        t.we = 1'b1; t.addr = 16'h1234; t.wd = 16'hBEEF;
        q0.push_back(t);
        run_until_idle(60, "d1_timeout");
        sram[int'({16'h0040, 1'b0})] = 8'h5A;
        sram[int'({16'h0040, 1'b1})] = 8'hC3;
        ref_mem[int'(16'h0040)] = 16'hC35A;
        t.we = 1'b0; t.addr = 16'h0040; t.wd = 16'h0000;
        q1.push_back(t);
        run_until_idle(60, "d2_timeout");
        chk("d2_rd1", 32'(rd1), 32'h0000C35A);
        chk("d2_rd0", 32'(rd0), 32'h00000000);

        // Sustained contention: grants must alternate starting with port 0
        obs_port.delete();
        obs_cyc.delete();
        repeat (4) begin
            q0.push_back(rand_txn());
            q1.push_back(rand_txn());
        end
        run_until_idle(200, "rr_timeout");
        chk("rr_count", 32'(obs_port.size()), 32'd8);
        for (int i = 0; i < obs_port.size(); i++)
            chk("rr_order", 32'(obs_port[i]), 32'(i % 2));
        check_gaps("rr_gap");

        // Reset in the first B0 cycle of a port 0 write, with port 1 also waiting
        t.we = 1'b1; t.addr = 16'h8001; t.wd = 16'h1357;
        q0.push_back(t);
        n = 0;
        while (!(m_busy && (cyc - m_gcyc) == 3) && n < 30) begin
            step(1'b0);
            n++;
        end
        chk("b0_reach", 32'(n < 30), 32'd1);
        do_reset();
        run_until_idle(100, "rst_timeout");
        chk("rst_tie_cnt", 32'(obs_port.size()), 32'd2);
        if (obs_port.size() > 0) chk("rst_tie", 32'(obs_port[0]), 32'd0);

        // Back-to-back accesses on port 0 only
        obs_port.delete();
        obs_cyc.delete();
        repeat (3) q0.push_back(rand_txn());
        run_until_idle(100, "b2b_timeout");
        chk("b2b_count", 32'(obs_cyc.size()), 32'd3);
        check_gaps("b2b_gap");

        // Random traffic
        repeat (500) step(1'b1);
        run_until_idle(300, "rand_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
